// File: rtl/sw_pkg.sv
// Shared constants and counter-width helper for the switch debouncer.
package sw_pkg;

    localparam int SW_WIDTH        = 8;
    localparam int SW_TICK_DIV     = 100000;
    localparam int SW_STABLE_TICKS = 20;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, committed bit and change pulse.
module sw_db_bit
    import sw_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS,
    parameter int CNT_W        = cnt_w(STABLE_TICKS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    input  logic tick_i,
    output logic sw_o,
    output logic chg_o,
    output logic chg_d_o
);

    localparam logic [CNT_W-1:0] BCNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             sw_q, sw_d;
    logic             chg_q, chg_d;

    // Agreement with the committed value clears the count ahead of any tick, so
    // a bounce back always restarts the stability window.
    always_comb begin
        bcnt_d = bcnt_q;
        sw_d   = sw_q;
        chg_d  = 1'b0;
        if (s2_q == sw_q) begin
            bcnt_d = '0;
        end else if (tick_i) begin
            if (bcnt_q == BCNT_LAST) begin
                sw_d   = s2_q;
                bcnt_d = '0;
                chg_d  = 1'b1;
            end else begin
                bcnt_d = bcnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser chain and debounce state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            bcnt_q <= '0;
            sw_q   <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            bcnt_q <= bcnt_d;
            sw_q   <= sw_d;
            chg_q  <= chg_d;
        end
    end

    assign sw_o    = sw_q;
    assign chg_o   = chg_q;
    assign chg_d_o = chg_d;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: shared tick prescaler, per-bit debounce cells, change summary.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] chg_mask,
    output logic             changed,
    output logic             tick
);

    localparam int               PCNT_W    = cnt_w(TICK_DIV);
    localparam int               BCNT_W    = cnt_w(STABLE_TICKS + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]  chg_d;
    logic              changed_q;

    assign tick = (pcnt_q == PCNT_LAST);

    // Free-running prescaler; wraps on the tick and ignores switch activity.
    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    end

    // Prescaler state and the registered OR of the next-cycle change mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            changed_q <= |chg_d;
        end
    end

    assign changed = changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_db_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (BCNT_W)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .sw_i    (sw_i[i]),
            .tick_i  (tick),
            .sw_o    (sw_o[i]),
            .chg_o   (chg_mask[i]),
            .chg_d_o (chg_d[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: dut_a uses TICK_DIV=1/STABLE_TICKS=4,
// dut_b uses TICK_DIV=10/STABLE_TICKS=3.
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_a, sw_b;
    logic [7:0] swo_a, chg_a, swo_b, chg_b;
    logic       changed_a, tick_a, changed_b, tick_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(8), .TICK_DIV(1), .STABLE_TICKS(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (sw_a),
        .sw_o     (swo_a),
        .chg_mask (chg_a),
        .changed  (changed_a),
        .tick     (tick_a)
    );

    sw_debounce #(.WIDTH(8), .TICK_DIV(10), .STABLE_TICKS(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (sw_b),
        .sw_o     (swo_b),
        .chg_mask (chg_b),
        .changed  (changed_b),
        .tick     (tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bnc [4];
        int         lat;
        logic       prev_tick;

        bnc[0] = 8'h88; bnc[1] = 8'h80; bnc[2] = 8'h88; bnc[3] = 8'h80;

        // Reset held with switches high.
        rst  = 1'b0;
        sw_a = 8'hFF;
        sw_b = 8'h00;
        #12;
        cyc(3);
        chk("rst_sw_o",     swo_a, 8'h00);
        chk("rst_chg_mask", chg_a, 8'h00);
        chk("rst_changed",  changed_a, 1'b0);
        chk("rst_tick_b",   tick_b, 1'b0);
        chk("rst_sw_o_b",   swo_b, 8'h00);

        // Release: full window before commit; prescaler first tick at TICK_DIV-1.
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (k == 1) chk("tick_div1", tick_a, 1'b1);
            if (k == 5) chk("rel_hold", swo_a, 8'h00);
            if (k == 6) begin
                chk("rel_commit",  swo_a, 8'hFF);
                chk("rel_mask",    chg_a, 8'hFF);
                chk("rel_changed", changed_a, 1'b1);
            end
            if (k == 7) begin
                chk("rel_mask_end",    chg_a, 8'h00);
                chk("rel_changed_end", changed_a, 1'b0);
                chk("rel_sw_o_hold",   swo_a, 8'hFF);
            end
            if (k == 8)  chk("first_tick_pre",  tick_b, 1'b0);
            if (k == 9)  chk("first_tick",      tick_b, 1'b1);
            if (k == 10) chk("first_tick_post", tick_b, 1'b0);
        end

        // Clean step 00 -> 80.
        sw_a = 8'h00;
        cyc(8);
        chk("step_base", swo_a, 8'h00);
        sw_a = 8'h80;
        cyc(5);
        chk("step_hold",      swo_a, 8'h00);
        chk("step_hold_mask", chg_a, 8'h00);
        cyc(1);
        chk("step_sw_o",    swo_a, 8'h80);
        chk("step_mask",    chg_a, 8'h80);
        chk("step_changed", changed_a, 1'b1);
        cyc(1);
        chk("step_sw_o_hold", swo_a, 8'h80);
        chk("step_mask_end",  chg_a, 8'h00);
        chk("step_chg_end",   changed_a, 1'b0);

        // Bounce on bit 3 with 2-cycle dwell, then stable high.
        for (int i = 0; i < 4; i++) begin
            sw_a = bnc[i];
            for (int j = 0; j < 2; j++) begin
                cyc(1);
                chk("bnc_hold",    swo_a, 8'h80);
                chk("bnc_changed", changed_a, 1'b0);
            end
        end
        sw_a = 8'h88;
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            chk("bnc_final_hold", swo_a, 8'h80);
        end
        cyc(1);
        chk("bnc_commit", swo_a, 8'h88);
        chk("bnc_mask",   chg_a, 8'h08);

        // Two bits rising together.
        sw_a = 8'h00;
        cyc(8);
        chk("multi_base", swo_a, 8'h00);
        sw_a = 8'h41;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 5) chk("multi_pre", changed_a, 1'b0);
            if (k == 6) begin
                chk("multi_mask",    chg_a, 8'h41);
                chk("multi_changed", changed_a, 1'b1);
                chk("multi_sw_o",    swo_a, 8'h41);
            end
            if (k == 7) chk("multi_post", changed_a, 1'b0);
        end

        // Reset while bit 3 is part-way through its window.
        sw_a = 8'h49;
        cyc(4);
        chk("mid_pre", swo_a, 8'h41);
        rst = 1'b0;
        #1;
        chk("mid_async_sw_o", swo_a, 8'h00);
        chk("mid_async_mask", chg_a, 8'h00);
        chk("mid_async_chg",  changed_a, 1'b0);
        cyc(2);
        chk("mid_held", swo_a, 8'h00);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (k == 5) chk("mid_rel_hold", swo_a, 8'h00);
            if (k == 6) begin
                chk("mid_rel_commit", swo_a, 8'h49);
                chk("mid_rel_mask",   chg_a, 8'h49);
            end
        end

        // Prescaled commit on dut_b bit 0.
        lat       = -1;
        sw_b      = 8'h01;
        prev_tick = tick_b;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && swo_b[0]) begin
                lat = k - 2;
                chk("presc_on_tick", prev_tick, 1'b1);
                chk("presc_mask",    chg_b, 8'h01);
            end
            prev_tick = tick_b;
        end
        chk("presc_done",      (lat >= 0), 1'b1);
        chk("presc_lat_range", (lat >= 21 && lat <= 30), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
